// File: rtl/smvm_stream_tx_if.sv
// -----------------------------------------------------------------------------
// smvm_stream_tx_if
//
// Purpose: serial link from the SMVM stream transmitter to the SMVM core
// input ports. One beat per clock while out_valid is high; every field is
// zero whenever out_valid is low.
//
// Signals:
//   val_out   [7:0]  to SMVM val_in
//   col_out   [2:0]  to SMVM col_in
//   ipv_out          to SMVM ipv_in
//   out_valid        to SMVM in_valid
//
// Modports:
//   master - transmitter side (drives the link)
//   slave  - SMVM core side (observes the link)
// -----------------------------------------------------------------------------
interface smvm_stream_tx_if;
  logic [7:0] val_out;
  logic [2:0] col_out;
  logic       ipv_out;
  logic       out_valid;

  modport master (
    output val_out,
    output col_out,
    output ipv_out,
    output out_valid
  );

  modport slave (
    input val_out,
    input col_out,
    input ipv_out,
    input out_valid
  );
endinterface

// File: rtl/smvm_stream_tx.sv
// -----------------------------------------------------------------------------
// smvm_stream_tx
//
// Purpose: holds a dense vector and a sparse nonzero list loaded by the host,
// and on start emits the complete SMVM input stream:
//   rows header, cols header, cols vector values, then P (value/ipv, column)
//   pairs where P = ceil(nnz/K)*K (entries at or beyond nnz are zero padding),
// followed by GAP_CYCLES idle cycles and a one-cycle done pulse.
//
// Every beat is a 12-bit word W mapped onto the link as
//   val_out = W[11:4], ipv_out = W[3], col_out = W[2:0]
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cfg_rows/cols/nnz stream configuration, latched when start is accepted
//   vec_wr_*          vector memory write port (ignored while busy)
//   nz_wr_*           nonzero memory write port (ignored while busy)
//   start             single-cycle request to transmit
//   busy              transmission in progress (includes the done cycle)
//   done              one-cycle completion pulse
//   err               one-cycle pulse when a start is rejected for bad config
//   tx                stream link to the SMVM core (master side)
// -----------------------------------------------------------------------------
module smvm_stream_tx #(
  parameter int K          = 4,
  parameter int MAX_COLS   = 128,
  parameter int MAX_NNZ    = 256,
  parameter int GAP_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cfg_rows,
  input  logic [7:0]       cfg_cols,
  input  logic [8:0]       cfg_nnz,
  input  logic             vec_wr_en,
  input  logic [6:0]       vec_wr_addr,
  input  logic [7:0]       vec_wr_data,
  input  logic             nz_wr_en,
  input  logic [7:0]       nz_wr_addr,
  input  logic [7:0]       nz_wr_val,
  input  logic [7:0]       nz_wr_col,
  input  logic             nz_wr_last,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  smvm_stream_tx_if.master tx
);

  localparam int VEC_AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int NZ_AW  = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_ROWS,
    S_HDR_COLS,
    S_VEC,
    S_NZ_VAL,
    S_NZ_IDX,
    S_GAP,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage. Memories have no reset so their contents survive rst; a stream
  // aborted by reset can be replayed from the same data.
  // ---------------------------------------------------------------------------
  logic [7:0]  vec_mem [MAX_COLS];
  logic [16:0] nz_mem  [MAX_NNZ];   // {last, col[7:0], val[7:0]}

  // Registered state (the state names the beat currently on the link).
  state_t            state_reg;
  logic [7:0]        cols_reg;
  logic [8:0]        nnz_reg;
  logic [9:0]        p_reg;
  logic [7:0]        vec_idx_reg;
  logic [9:0]        nz_idx_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;

  // Write port: a write in the same cycle as an accepted start still lands,
  // because busy only rises on the following cycle.
  always_ff @(posedge clk) begin
    if (vec_wr_en && !busy_reg) begin
      vec_mem[vec_wr_addr[VEC_AW-1:0]] <= vec_wr_data;
    end
    if (nz_wr_en && !busy_reg) begin
      nz_mem[nz_wr_addr[NZ_AW-1:0]] <= {nz_wr_last, nz_wr_col, nz_wr_val};
    end
  end

  // ---------------------------------------------------------------------------
  // Next-beat fetch. Outputs are registered, so each edge loads the word for
  // the beat that follows the current one; the read index therefore looks one
  // element ahead of the index register.
  // ---------------------------------------------------------------------------
  logic              cfg_ok;
  logic [9:0]        p_calc;
  logic [VEC_AW-1:0] vec_rd_idx;
  logic [7:0]        vec_rd_data;
  logic [9:0]        nz_rd_idx;
  logic [16:0]       nz_rd_entry;
  logic              nz_rd_pad;
  logic [11:0]       nz_val_word;
  logic [11:0]       nz_col_word;
  logic              vec_last;
  logic              nz_last;

  always_comb begin
    cfg_ok = (cfg_cols != 8'd0) &&
             (int'(cfg_cols) <= MAX_COLS) &&
             (int'(cfg_nnz) <= MAX_NNZ);

    // Round the nonzero count up to a whole number of ALU lanes.
    p_calc = ((10'(cfg_nnz) + 10'(K - 1)) / 10'(K)) * 10'(K);

    vec_rd_idx = '0;
    if (state_reg != S_HDR_COLS) begin
      vec_rd_idx = vec_idx_reg[VEC_AW-1:0] + VEC_AW'(1);
    end
    vec_rd_data = vec_mem[vec_rd_idx];

    // In NZ_VAL the pending beat is the column of the same entry; elsewhere
    // it is the value of the next entry (entry 0 when leaving VEC).
    nz_rd_idx = nz_idx_reg + 10'd1;
    if (state_reg == S_NZ_VAL) begin
      nz_rd_idx = nz_idx_reg;
    end else if (state_reg == S_VEC) begin
      nz_rd_idx = 10'd0;
    end
    nz_rd_entry = nz_mem[nz_rd_idx[NZ_AW-1:0]];
    nz_rd_pad   = (nz_rd_idx >= {1'b0, nnz_reg});

    nz_val_word = 12'h000;
    nz_col_word = 12'h000;
    if (!nz_rd_pad) begin
      nz_val_word = {nz_rd_entry[7:0], nz_rd_entry[16], 3'b000};
      nz_col_word = {4'h0, nz_rd_entry[15:8]};
    end

    vec_last = (vec_idx_reg == (cols_reg - 8'd1));
    nz_last  = (nz_idx_reg == (p_reg - 10'd1));
  end

  // ---------------------------------------------------------------------------
  // Sequencer with registered link outputs. Defaults drive an idle link and
  // clear the pulses; each state overrides only what its next beat needs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cols_reg     <= 8'd0;
      nnz_reg      <= 9'd0;
      p_reg        <= 10'd0;
      vec_idx_reg  <= 8'd0;
      nz_idx_reg   <= 10'd0;
      gap_cnt_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      tx.out_valid <= 1'b0;
      tx.val_out   <= 8'd0;
      tx.ipv_out   <= 1'b0;
      tx.col_out   <= 3'd0;
    end else begin
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      tx.out_valid <= 1'b0;
      {tx.val_out, tx.ipv_out, tx.col_out} <= 12'h000;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state_reg    <= S_HDR_ROWS;
              busy_reg     <= 1'b1;
              cols_reg     <= cfg_cols;
              nnz_reg      <= cfg_nnz;
              p_reg        <= p_calc;
              tx.out_valid <= 1'b1;
              {tx.val_out, tx.ipv_out, tx.col_out} <= {4'h0, cfg_rows};
            end else begin
              err_reg <= 1'b1;
            end
          end
        end

        S_HDR_ROWS: begin
          state_reg    <= S_HDR_COLS;
          tx.out_valid <= 1'b1;
          {tx.val_out, tx.ipv_out, tx.col_out} <= {4'h0, cols_reg};
        end

        S_HDR_COLS: begin
          state_reg    <= S_VEC;
          vec_idx_reg  <= 8'd0;
          tx.out_valid <= 1'b1;
          {tx.val_out, tx.ipv_out, tx.col_out} <= {vec_rd_data, 4'h0};
        end

        S_VEC: begin
          if (vec_last) begin
            vec_idx_reg <= 8'd0;
            if (p_reg == 10'd0) begin
              // No nonzeros at all: the first idle cycle is already the gap.
              state_reg   <= S_GAP;
              gap_cnt_reg <= '0;
            end else begin
              state_reg    <= S_NZ_VAL;
              nz_idx_reg   <= 10'd0;
              tx.out_valid <= 1'b1;
              {tx.val_out, tx.ipv_out, tx.col_out} <= nz_val_word;
            end
          end else begin
            vec_idx_reg  <= vec_idx_reg + 8'd1;
            tx.out_valid <= 1'b1;
            {tx.val_out, tx.ipv_out, tx.col_out} <= {vec_rd_data, 4'h0};
          end
        end

        S_NZ_VAL: begin
          state_reg    <= S_NZ_IDX;
          tx.out_valid <= 1'b1;
          {tx.val_out, tx.ipv_out, tx.col_out} <= nz_col_word;
        end

        S_NZ_IDX: begin
          if (nz_last) begin
            nz_idx_reg  <= 10'd0;
            state_reg   <= S_GAP;
            gap_cnt_reg <= '0;
          end else begin
            nz_idx_reg   <= nz_idx_reg + 10'd1;
            state_reg    <= S_NZ_VAL;
            tx.out_valid <= 1'b1;
            {tx.val_out, tx.ipv_out, tx.col_out} <= nz_val_word;
          end
        end

        S_GAP: begin
          // The first gap cycle doubles as the in_valid-low slot that moves
          // the SMVM core into its calculate phase.
          if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_smvm_stream_tx.sv
`timescale 1ns/1ps
module tb_smvm_stream_tx;
  localparam int K          = 4;
  localparam int MAX_COLS   = 128;
  localparam int MAX_NNZ    = 256;
  localparam int GAP_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_rows, cfg_cols;
  logic [8:0] cfg_nnz;
  logic       vec_wr_en;
  logic [6:0] vec_wr_addr;
  logic [7:0] vec_wr_data;
  logic       nz_wr_en;
  logic [7:0] nz_wr_addr, nz_wr_val, nz_wr_col;
  logic       nz_wr_last;
  logic       start;
  logic       busy, done, err;

  always #5 clk = ~clk;

  smvm_stream_tx_if txif();

  smvm_stream_tx #(
    .K(K), .MAX_COLS(MAX_COLS), .MAX_NNZ(MAX_NNZ), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_nnz(cfg_nnz),
    .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data),
    .nz_wr_en(nz_wr_en), .nz_wr_addr(nz_wr_addr), .nz_wr_val(nz_wr_val),
    .nz_wr_col(nz_wr_col), .nz_wr_last(nz_wr_last),
    .start(start), .busy(busy), .done(done), .err(err),
    .tx(txif)
  );

  // Expected observation for one clock cycle.
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        valid;
    logic [11:0] w;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] words[$];
  int          last_len;

  // Reference copy of what the memories must hold.
  logic [7:0] vec_m [MAX_COLS];
  logic [7:0] nzv_m [MAX_NNZ];
  logic [7:0] nzc_m [MAX_NNZ];
  logic       nzl_m [MAX_NNZ];

  int total = 0;
  int bad   = 0;
  int txn   = 0;
  bit chk_en = 1'b0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
    end
  endfunction

  // Per-cycle compare: the queue holds the expected cycle-by-cycle trace;
  // once it is empty the block must sit idle.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      exp_t act;
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      act = {busy, done, err, txif.out_valid, txif.val_out, txif.ipv_out, txif.col_out};
      check("cycle", 32'(act), 32'(e));
    end
  end

  // Build the expected trace of a start issued in the current cycle.
  function automatic void build(input int rows, input int cols, input int nnz);
    exp_t e;
    int   p;
    bit   ok;
    ok = (cols >= 1) && (cols <= MAX_COLS) && (nnz <= MAX_NNZ);
    words.delete();
    e = '0;
    exp_q.push_back(e);                 // the start cycle itself is still idle
    if (!ok) begin
      e.err = 1'b1;
      exp_q.push_back(e);
      return;
    end
    p = ((nnz + K - 1) / K) * K;
    words.push_back(12'(rows));
    words.push_back(12'(cols));
    for (int i = 0; i < cols; i++) words.push_back({vec_m[i], 4'h0});
    for (int j = 0; j < p; j++) begin
      if (j < nnz) begin
        words.push_back({nzv_m[j], nzl_m[j], 3'b000});
        words.push_back({4'h0, nzc_m[j]});
      end else begin
        words.push_back(12'h000);
        words.push_back(12'h000);
      end
    end
    foreach (words[k]) begin
      e = '0; e.busy = 1'b1; e.valid = 1'b1; e.w = words[k];
      exp_q.push_back(e);
    end
    for (int g = 0; g < GAP_CYCLES; g++) begin
      e = '0; e.busy = 1'b1;
      exp_q.push_back(e);
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_vec(input int a, input logic [7:0] d, input bit commit);
    vec_wr_en = 1'b1; vec_wr_addr = 7'(a); vec_wr_data = d;
    tick();
    vec_wr_en = 1'b0;
    if (commit) vec_m[a] = d;
  endtask

  task automatic wr_nz(input int a, input logic [7:0] v, input logic [7:0] c,
                       input logic l, input bit commit);
    nz_wr_en = 1'b1; nz_wr_addr = 8'(a); nz_wr_val = v; nz_wr_col = c; nz_wr_last = l;
    tick();
    nz_wr_en = 1'b0;
    if (commit) begin
      nzv_m[a] = v; nzc_m[a] = c; nzl_m[a] = l;
    end
  endtask

  task automatic do_start(input int rows, input int cols, input int nnz);
    cfg_rows = 8'(rows); cfg_cols = 8'(cols); cfg_nnz = 9'(nnz);
    build(rows, cols, nnz);
    last_len = exp_q.size();
    $display("txn %0d: rows=%0d cols=%0d nnz=%0d expected_cycles=%0d",
             txn, rows, cols, nnz, last_len);
    txn++;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic fill_random(input int cols, input int nnz);
    for (int i = 0; i < cols; i++) wr_vec(i, 8'($urandom), 1'b1);
    for (int j = 0; j < nnz; j++)
      wr_nz(j, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
  endtask

  initial begin
    logic [7:0] v0;
    rst = 1'b1; start = 1'b0;
    cfg_rows = '0; cfg_cols = '0; cfg_nnz = '0;
    vec_wr_en = 1'b0; vec_wr_addr = '0; vec_wr_data = '0;
    nz_wr_en = 1'b0; nz_wr_addr = '0; nz_wr_val = '0; nz_wr_col = '0; nz_wr_last = 1'b0;
    repeat (3) tick();
    check("reset_outputs",
          32'({busy, done, err, txif.out_valid, txif.val_out, txif.ipv_out, txif.col_out}), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) tick();

    // Worked example: rows=2 cols=3 vec={5,-3,7}, four nonzeros.
    wr_vec(0, 8'd5, 1'b1); wr_vec(1, 8'hFD, 1'b1); wr_vec(2, 8'd7, 1'b1);
    wr_nz(0, 8'd1,   8'd0, 1'b0, 1'b1);
    wr_nz(1, 8'd2,   8'd2, 1'b1, 1'b1);
    wr_nz(2, 8'hFF,  8'd1, 1'b0, 1'b1);
    wr_nz(3, 8'd4,   8'd0, 1'b1, 1'b1);
    do_start(2, 3, 4);
    check("ex_beats",   32'(words.size()), 32'd13);
    check("ex_rows",    32'(words[0]), 32'h002);
    check("ex_cols",    32'(words[1]), 32'h003);
    check("ex_vec1",    32'(words[3]), 32'hFD0);
    check("ex_nz0_val", 32'(words[5]), 32'h010);
    check("ex_nz1_val", 32'(words[7]), 32'h028);
    check("ex_nz1_col", 32'(words[8]), 32'h002);
    check("ex_nz2_val", 32'(words[9]), 32'hFF0);
    check("ex_nz3_val", 32'(words[11]), 32'h048);
    check("ex_done_at", 32'(last_len - 1), 32'd22);
    drain();

    // nnz=5 pads to P=8; entry 2 carries column 100; slots 5..7 hold stale data.
    for (int i = 0; i < 4; i++) wr_vec(i, 8'($urandom), 1'b1);
    for (int j = 0; j < 8; j++)
      wr_nz(j, 8'($urandom_range(1, 255)), (j == 2) ? 8'd100 : 8'($urandom_range(1, 255)),
            1'b1, 1'b1);
    do_start(9, 4, 5);
    check("pad_beats",  32'(words.size()), 32'd22);
    check("col100_idx", 32'(words[11]), 32'h064);
    for (int k = 16; k < 22; k++) check("pad_zero", 32'(words[k]), 32'h000);
    drain();

    // No nonzeros: headers plus vector only.
    do_start(7, 2, 0);
    check("nnz0_beats",   32'(words.size()), 32'd4);
    check("nnz0_done_at", 32'(last_len - 1), 32'd13);
    drain();

    // Rejected configurations.
    do_start(1, 0, 3);    drain();
    do_start(1, 129, 3);  drain();
    do_start(1, 4, 257);  drain();

    // Writes and a start while busy are ignored; replay must match.
    do_start(3, 4, 5);
    while (exp_q.size() > 0 && exp_q[0].busy) begin
      case ($urandom_range(0, 2))
        0: wr_vec($urandom_range(0, 3), 8'($urandom), 1'b0);
        1: wr_nz($urandom_range(0, 7), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        default: begin
          cfg_cols = 8'd2; cfg_nnz = 9'd0;
          start = 1'b1; tick(); start = 1'b0;
        end
      endcase
    end
    drain();
    do_start(3, 4, 5);
    drain();

    // Write in the same cycle as start is visible in the stream.
    v0 = 8'($urandom);
    vec_wr_en = 1'b1; vec_wr_addr = 7'd0; vec_wr_data = v0; vec_m[0] = v0;
    do_start(4, 4, 5);
    vec_wr_en = 1'b0;
    drain();

    // Reset mid-vector: outputs clear at once, no done, then a clean replay.
    fill_random(20, 6);
    do_start(5, 20, 6);
    repeat (5) tick();
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_async",
          32'({busy, done, err, txif.out_valid, txif.val_out, txif.ipv_out, txif.col_out}), 32'd0);
    tick();
    rst = 1'b0;
    repeat (30) tick();
    do_start(5, 20, 6);
    drain();

    // Randomized configurations.
    for (int r = 0; r < 6; r++) begin
      int c, n;
      c = $urandom_range(1, 40);
      n = $urandom_range(0, 40);
      fill_random(c, n);
      do_start($urandom_range(0, 255), c, n);
      drain();
    end

    // Largest legal configuration.
    fill_random(MAX_COLS, MAX_NNZ);
    do_start(255, MAX_COLS, MAX_NNZ);
    drain();

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/smvm_stream_tx.md
Name: smvm_stream_tx

Overview:
- Transmitter for the SMVM serial input protocol. It holds a dense vector and a sparse nonzero list that the host loads through write ports.
- On start it emits the full SMVM input stream in order: rows header, cols header, vector values, then K-padded (value/ipv, column) pairs.
- It then holds the link idle for a programmable gap and pulses done.
- It sits between the host/testbench memory and the SMVM input ports (val_in, col_in, ipv_in, in_valid).

Parameters:
K, 4, SMVM ALU lane count; the nonzero stream is zero-padded to a multiple of K.
MAX_COLS, 128, vector memory depth (max cfg_cols).
MAX_NNZ, 256, nonzero memory depth.
GAP_CYCLES, 8, idle cycles after the last valid beat before done (covers SMVM CAL/OUT and result drain).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_rows  in  8  matrix row count, latched at start
cfg_cols  in  8  vector length, latched at start; legal 1..MAX_COLS
cfg_nnz  in  9  nonzero count, latched at start; legal 0..MAX_NNZ
vec_wr_en  in  1  vector memory write strobe
vec_wr_addr  in  7  vector element index
vec_wr_data  in  8  signed vector element
nz_wr_en  in  1  nonzero memory write strobe
nz_wr_addr  in  8  nonzero entry index
nz_wr_val  in  8  signed matrix value
nz_wr_col  in  8  column index of entry
nz_wr_last  in  1  ipv flag (1 = last nonzero of its row)
start  in  1  begin transmission (single-cycle pulse)
busy  out  1  transmission in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse: start rejected
val_out  out  8  to SMVM val_in
col_out  out  3  to SMVM col_in
ipv_out  out  1  to SMVM ipv_in
out_valid  out  1  to SMVM in_valid

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Memory contents are unaffected. Reset asserted mid-stream forces outputs to 0 immediately (asynchronous) and aborts without a done pulse.
- Stream outputs are registered. When out_valid=0, val_out, col_out and ipv_out are all 0.
- 12-bit word W maps to the outputs as: val_out=W[11:4], ipv_out=W[3], col_out=W[2:0]. This matches SMVM's {val_in, ipv_in, col_in} index format.
- Writes: accepted only while busy=0. Writes while busy=1 are ignored. A write in the same cycle as an accepted start is committed and is visible to the stream.
- start with busy=0:
  - If cfg_cols==0, cfg_cols>MAX_COLS, or cfg_nnz>MAX_NNZ, then err=1 the next cycle and the block stays IDLE.
  - Otherwise it latches the config, computes P = ceil(cfg_nnz/K)*K, sets busy=1 the next cycle, and enters HDR_ROWS.
- start while busy=1 is ignored (no err).
- States:
  - IDLE: out_valid=0.
  - HDR_ROWS (1 cycle): W={4'b0,rows}, out_valid=1.
  - HDR_COLS (1 cycle): W={4'b0,cols}.
  - VEC (cols cycles): val_out=vec[i] for i=0..cols-1, ipv_out=0, col_out=0.
  - NZ_VAL: val_out=nz_val[j], ipv_out=nz_last[j], col_out=0.
  - NZ_IDX: W={4'b0,nz_col[j]}, then j++. NZ_VAL and NZ_IDX alternate for j=0..P-1.
  - Padding entries (j>=cfg_nnz) send val=0, ipv=0, col=0.
  - If P=0, VEC goes directly to GAP.
  - GAP (GAP_CYCLES cycles): out_valid=0. The first GAP cycle is the in_valid-low VAL slot that moves SMVM into CAL.
  - DONE (1 cycle): done=1, busy=1, then IDLE with busy=0.
- Timing: with start accepted at cycle t:
  - first valid beat at t+1;
  - last valid beat at t+2+cols+2P;
  - done at t+3+cols+2P+GAP_CYCLES;
  - a new start is accepted the cycle after done.
- Counters: the vector index wraps to 0 on leaving VEC and the entry index clears on leaving NZ_IDX. No wrap occurs inside a transfer.

Test Plan:
- rows=2, cols=3, vec={5,-3,7}, nnz=4 {(1,c0,0),(2,c2,1),(-1,c1,0),(4,c0,1)}, start@t -> beats t+1..t+13 give headers, then 5/0xFD/7, then alternating pairs (val/ipv, col); out_valid=0 at t+14; done at t+22.
- nnz=5, K=4 -> P=8, 16 nz beats; entries 5..7 are val=0, ipv=0, col=0.
- nz_wr_col=100 -> its IDX beat gives val_out=0x06, ipv_out=0, col_out=3'b100.
- nnz=0, cols=2 -> 4 valid beats only (headers + vector), then GAP and done.
- start with cfg_cols=0 -> err pulse next cycle, out_valid stays 0. Writes and start during busy -> ignored; memory is unchanged after done.
- rst asserted during VEC -> all outputs 0 asynchronously, no done. A subsequent start replays the full stream from HDR_ROWS with the same memory contents.
